// File: rtl/servo_pwm_pkg.sv
// -----------------------------------------------------------------------------
// servo_pwm_pkg
// Shared definitions for the servo PWM core and its bus-facing register
// wrapper. The package holds:
//   - the default channel count and value width;
//   - the per-channel field packing on the E/T/D buses;
//   - the wrapper register map (E/T/D per channel, fixed channel stride);
//   - the channel operating modes.
// No ports (package).
// -----------------------------------------------------------------------------
package servo_pwm_pkg;

    localparam int NCH_DEF = 8;   // number of PWM channels
    localparam int CW_DEF  = 32;  // width of period/duty/counter in cycles

    // Wrapper register map: byte offsets inside one channel block
    localparam int REG_E_OFS = 'h0;
    localparam int REG_T_OFS = 'h4;
    localparam int REG_D_OFS = 'h8;
    localparam int CH_STRIDE = 'hC;

    typedef enum logic [1:0] {
        FIELD_E = 2'd0,
        FIELD_T = 2'd1,
        FIELD_D = 2'd2
    } field_e;

    // Channel operating mode, derived each cycle from enable and active period
    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,  // disabled: continuous shadow reload
        CH_IDLE = 2'd1,  // enabled but active period is zero
        CH_RUN  = 2'd2   // enabled with a valid period
    } ch_mode_e;

    // LSB of channel ch inside a packed per-channel bus of cw-bit fields
    function automatic int ch_field_lsb(input int ch, input int cw);
        return ch * cw;
    endfunction

    // Byte address of a channel register in the wrapper map
    function automatic logic [15:0] reg_addr(input int ch, input field_e f);
        int ofs;
        case (f)
            FIELD_E: ofs = REG_E_OFS;
            FIELD_T: ofs = REG_T_OFS;
            FIELD_D: ofs = REG_D_OFS;
            default: ofs = REG_E_OFS;
        endcase
        return 16'(ch * CH_STRIDE + ofs);
    endfunction

endpackage

// File: rtl/servo_pwm_core_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM channel: period counter, shadow/active T/D pair, duty compare and
// end-of-period strobe. New T/D are taken only on the last cycle of a period
// (or continuously while disabled / while the active period is zero), so a
// running output never sees a truncated or doubled pulse.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   channel enable (level)
//   period     in   shadow period T (cycles)
//   duty       in   shadow high time D (cycles)
//   pwm        out  registered PWM output, lags the counter by one cycle
//   period_end out  one-cycle pulse on the last cycle of each active period
// -----------------------------------------------------------------------------
module pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] duty,
    output logic          pwm,
    output logic          period_end
);

    ch_mode_e      mode;
    logic [CW-1:0] cnt_p0;
    logic [CW-1:0] t_act_p0;
    logic [CW-1:0] d_act_p0;
    logic          last_p0;
    logic          pwm_p1;
    logic          pend_p1;

    always_comb begin
        mode = CH_RUN;
        if (!en) begin
            mode = CH_OFF;
        end else if (t_act_p0 == '0) begin
            mode = CH_IDLE;
        end
    end

    // Only meaningful in CH_RUN, where t_act_p0 > 0 so the subtraction is safe
    assign last_p0 = (cnt_p0 == t_act_p0 - CW'(1));

    // Stage p0: period counter and active T/D registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0   <= '0;
            t_act_p0 <= '0;
            d_act_p0 <= '0;
        end else begin
            case (mode)
                CH_RUN: begin
                    if (last_p0) begin
                        cnt_p0   <= '0;
                        t_act_p0 <= period;
                        d_act_p0 <= duty;
                    end else begin
                        cnt_p0   <= cnt_p0 + CW'(1);
                    end
                end
                default: begin
                    // Disabled or zero period: hold at the start of a fresh
                    // period and track the shadow values every cycle.
                    cnt_p0   <= '0;
                    t_act_p0 <= period;
                    d_act_p0 <= duty;
                end
            endcase
        end
    end

    // Stage p1: registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_p1  <= 1'b0;
            pend_p1 <= 1'b0;
        end else if (mode == CH_RUN) begin
            pwm_p1  <= (cnt_p0 < d_act_p0);
            pend_p1 <= last_p0;
        end else begin
            pwm_p1  <= 1'b0;
            pend_p1 <= 1'b0;
        end
    end

    assign pwm        = pwm_p1;
    assign period_end = pend_p1;

endmodule

// File: rtl/servo_pwm_core.sv
// -----------------------------------------------------------------------------
// servo_pwm_core
// Multi-channel servo PWM generator. Slices the packed per-channel buses and
// instantiates one independent pwm_channel per channel.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   en_i          in   [NCH]     per-channel enable, bit k = channel k
//   period_i      in   [NCH*CW]  per-channel period, channel k at [k*CW +: CW]
//   duty_i        in   [NCH*CW]  per-channel high time, same packing
//   pwm_o         out  [NCH]     registered PWM outputs
//   period_end_o  out  [NCH]     last-cycle-of-period strobes
// -----------------------------------------------------------------------------
module servo_pwm_core
    import servo_pwm_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    en_i,
    input  logic [NCH*CW-1:0] period_i,
    input  logic [NCH*CW-1:0] duty_i,
    output logic [NCH-1:0]    pwm_o,
    output logic [NCH-1:0]    period_end_o
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwm_channel #(
            .CW (CW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en_i[k]),
            .period     (period_i[ch_field_lsb(k, CW) +: CW]),
            .duty       (duty_i[ch_field_lsb(k, CW) +: CW]),
            .pwm        (pwm_o[k]),
            .period_end (period_end_o[k])
        );
    end

endmodule

// File: tb/tb_servo_pwm_core.sv
module tb_servo_pwm_core;

    localparam int NCH = 8;
    localparam int CW  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    en;
    logic [NCH*CW-1:0] period;
    logic [NCH*CW-1:0] duty;
    logic [NCH-1:0]    pwm;
    logic [NCH-1:0]    pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servo_pwm_core #(.NCH(NCH), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .period_i     (period),
        .duty_i       (duty),
        .pwm_o        (pwm),
        .period_end_o (pend)
    );

    // Expected outputs after the n-th enabled edge (n = 1 is the first edge
    // with the channel enabled and a valid active period): cnt was (n-1)%t.
    function automatic logic exp_pwm(input int n, input int t, input int d);
        return ((n - 1) % t) < d;
    endfunction

    function automatic logic exp_pend(input int n, input int t);
        return ((n - 1) % t) == (t - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [CW-1:0] t, input logic [CW-1:0] d);
        period[k*CW +: CW] = t;
        duty[k*CW +: CW]   = d;
    endtask

    task automatic quiesce();
        en = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en     = '1;
        period = '0;
        duty   = '0;
        for (int k = 0; k < NCH; k++) set_ch(k, 4, 2);
        #3;
        checks++;
        if (pwm !== '0 || pend !== '0) begin
            errors++;
            $display("FAIL reset_async got pwm=%b pend=%b exp 0/0", pwm, pend);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pwm !== '0 || pend !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got pwm=%b pend=%b exp 0/0", i, pwm, pend);
            end
        end
        en = '0;
        #2 rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        quiesce();
        set_ch(0, 10, 3);
        tick();
        en[0] = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            checks++;
            if (pwm[0] !== exp_pwm(n, 10, 3)) begin
                errors++;
                $display("FAIL basic_pwm n=%0d got %b exp %b", n, pwm[0], exp_pwm(n, 10, 3));
            end
            checks++;
            if (pend[0] !== exp_pend(n, 10)) begin
                errors++;
                $display("FAIL basic_pend n=%0d got %b exp %b", n, pend[0], exp_pend(n, 10));
            end
            checks++;
            if (pwm[NCH-1:1] !== '0 || pend[NCH-1:1] !== '0) begin
                errors++;
                $display("FAIL basic_others n=%0d got pwm=%b pend=%b exp 0", n, pwm, pend);
            end
        end
    endtask

    task automatic test_duty_change();
        int d;
        quiesce();
        set_ch(0, 10, 3);
        tick();
        en[0] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            d = (n <= 10) ? 3 : 7;
            checks++;
            if (pwm[0] !== exp_pwm(n, 10, d) || pend[0] !== exp_pend(n, 10)) begin
                errors++;
                $display("FAIL duty_change n=%0d got pwm=%b pend=%b exp %b/%b",
                         n, pwm[0], pend[0], exp_pwm(n, 10, d), exp_pend(n, 10));
            end
            if (n == 5) duty[0 +: CW] = 5;
            if (n == 8) duty[0 +: CW] = 7;
        end
    endtask

    task automatic test_full_duty();
        int dv [2] = '{20, 25};
        for (int j = 0; j < 2; j++) begin
            quiesce();
            set_ch(1, 20, dv[j]);
            tick();
            en[1] = 1'b1;
            for (int n = 1; n <= 40; n++) begin
                tick();
                checks++;
                if (pwm[1] !== 1'b1 || pend[1] !== exp_pend(n, 20)) begin
                    errors++;
                    $display("FAIL full_duty d=%0d n=%0d got pwm=%b pend=%b exp 1/%b",
                             dv[j], n, pwm[1], pend[1], exp_pend(n, 20));
                end
            end
        end
    endtask

    task automatic test_zero_period();
        logic ep, ee;
        quiesce();
        set_ch(2, 0, 5);
        tick();
        en[2] = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            tick();
            checks++;
            if (pwm[2] !== 1'b0 || pend[2] !== 1'b0) begin
                errors++;
                $display("FAIL zero_period n=%0d got pwm=%b pend=%b exp 0/0", n, pwm[2], pend[2]);
            end
        end
        period[2*CW +: CW] = 8;
        for (int m = 1; m <= 17; m++) begin
            tick();
            ep = (m == 1) ? 1'b0 : exp_pwm(m - 1, 8, 5);
            ee = (m == 1) ? 1'b0 : exp_pend(m - 1, 8);
            checks++;
            if (pwm[2] !== ep || pend[2] !== ee) begin
                errors++;
                $display("FAIL zero_to_valid m=%0d got pwm=%b pend=%b exp %b/%b", m, pwm[2], pend[2], ep, ee);
            end
        end
    endtask

    task automatic test_disable();
        quiesce();
        set_ch(3, 100, 50);
        tick();
        en[3] = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            tick();
            checks++;
            if (pwm[3] !== exp_pwm(n, 100, 50) || pend[3] !== exp_pend(n, 100)) begin
                errors++;
                $display("FAIL dis_run n=%0d got pwm=%b pend=%b", n, pwm[3], pend[3]);
            end
        end
        en[3] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (pwm[3] !== 1'b0 || pend[3] !== 1'b0) begin
                errors++;
                $display("FAIL dis_off n=%0d got pwm=%b pend=%b exp 0/0", n, pwm[3], pend[3]);
            end
        end
        en[3] = 1'b1;
        for (int n = 1; n <= 101; n++) begin
            tick();
            checks++;
            if (pwm[3] !== exp_pwm(n, 100, 50) || pend[3] !== exp_pend(n, 100)) begin
                errors++;
                $display("FAIL dis_restart n=%0d got pwm=%b pend=%b exp %b/%b",
                         n, pwm[3], pend[3], exp_pwm(n, 100, 50), exp_pend(n, 100));
            end
        end
    endtask

    task automatic test_period_one();
        quiesce();
        set_ch(4, 1, 1);
        tick();
        en[4] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            checks++;
            if (pwm[4] !== 1'b1 || pend[4] !== 1'b1) begin
                errors++;
                $display("FAIL t1_d1 n=%0d got pwm=%b pend=%b exp 1/1", n, pwm[4], pend[4]);
            end
        end
        quiesce();
        set_ch(4, 1, 0);
        set_ch(5, 6, 0);
        tick();
        en[4] = 1'b1;
        en[5] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (pwm[4] !== 1'b0 || pend[4] !== 1'b1) begin
                errors++;
                $display("FAIL t1_d0 n=%0d got pwm=%b pend=%b exp 0/1", n, pwm[4], pend[4]);
            end
            checks++;
            if (pwm[5] !== 1'b0 || pend[5] !== exp_pend(n, 6)) begin
                errors++;
                $display("FAIL d0 n=%0d got pwm=%b pend=%b exp 0/%b", n, pwm[5], pend[5], exp_pend(n, 6));
            end
        end
    endtask

    task automatic test_reset_all();
        logic [NCH-1:0] ep, ee;
        quiesce();
        for (int k = 0; k < NCH; k++) set_ch(k, 10 + k, 4 + k);
        tick();
        en = '1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            for (int k = 0; k < NCH; k++) begin
                ep[k] = exp_pwm(n, 10 + k, 4 + k);
                ee[k] = exp_pend(n, 10 + k);
            end
            checks++;
            if (pwm !== ep || pend !== ee) begin
                errors++;
                $display("FAIL all_run n=%0d got pwm=%b pend=%b exp %b/%b", n, pwm, pend, ep, ee);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pwm !== '0 || pend !== '0) begin
            errors++;
            $display("FAIL all_async_rst got pwm=%b pend=%b exp 0/0", pwm, pend);
        end
        tick();
        #2 rst_n = 1'b1;
        for (int m = 1; m <= 25; m++) begin
            tick();
            for (int k = 0; k < NCH; k++) begin
                ep[k] = (m == 1) ? 1'b0 : exp_pwm(m - 1, 10 + k, 4 + k);
                ee[k] = (m == 1) ? 1'b0 : exp_pend(m - 1, 10 + k);
            end
            checks++;
            if (pwm !== ep || pend !== ee) begin
                errors++;
                $display("FAIL all_restart m=%0d got pwm=%b pend=%b exp %b/%b", m, pwm, pend, ep, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_full_duty();
        test_zero_period();
        test_disable();
        test_period_one();
        test_reset_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
